prog_freq_divider: RTL

//  Multi-channel programmable clock-enable/frequency divider; successor to the fixed divide-by-20 divider.

---
 rtl/freq_div_pkg.sv | 19 +
 rtl/freq_div_channel.sv | 89 ++++++++
 rtl/prog_freq_divider.sv | 53 +++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable frequency divider.
// half_ceil works at the widest supported counter width; callers narrow it.
package freq_div_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_DIV_VAL = 20;
  localparam int MAX_CNT_W   = 32;

  // ceil(n/2) with one extra bit so an all-ones divisor cannot wrap to zero.
  function automatic logic [MAX_CNT_W:0] half_ceil(input logic [MAX_CNT_W-1:0] n);
    return ({1'b0, n} + (MAX_CNT_W+1)'(1)) >> 1;
  endfunction

  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: phase counter, active/pending divisor and registered outputs.
// A loaded divisor waits in n_pend until the channel reaches a period boundary.
module freq_div_channel
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [CNT_W-1:0] load_div,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam int HW = CNT_W + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic             pending;
  logic             at_end;

  logic             take_pend;
  logic [CNT_W-1:0] n_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [HW-1:0]    h;
  logic             last;

  always_comb begin
    take_pend = at_end & pending;
    n_next    = take_pend ? n_pend : n_act;
    cnt_inc   = cnt + CNT_W'(1);
    h         = HW'(half_ceil(MAX_CNT_W'(n_act)));
    last      = (cnt_inc == n_act - CNT_W'(1));
  end

  // NOTE: every state register uses <= so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      n_act   <= CNT_W'(DEF_DIV);
      n_pend  <= '0;
      pending <= 1'b0;
      at_end  <= 1'b1;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        if (at_end) begin
          if (take_pend) begin
            n_act   <= n_pend;
            pending <= 1'b0;
          end
          cnt <= '0;
          if (n_next == '0) begin
            // Divisor zero parks the channel at a boundary with the output low.
            clk_out <= 1'b0;
            tick    <= 1'b0;
            at_end  <= 1'b1;
          end else begin
            clk_out <= 1'b1;
            tick    <= (n_next == CNT_W'(1));
            at_end  <= (n_next == CNT_W'(1));
          end
        end else begin
          cnt     <= cnt_inc;
          clk_out <= ({1'b0, cnt_inc} < h);
          tick    <= last;
          at_end  <= last;
        end
      end else begin
        tick <= 1'b0;
      end

      // Acceptance needs pending low beforehand, so it never collides with a consume.
      if (load_valid && !pending) begin
        n_pend  <= load_div;
        pending <= 1'b1;
      end
    end
  end

  assign pend = pending;

endmodule

// File: rtl/prog_freq_divider.sv
// Multi-channel programmable divider: decodes the shared cfg bus to per-channel
// loads and gathers the per-channel clock and tick outputs.
module prog_freq_divider
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DEF_DIV = DEF_DIV_VAL,
  localparam int CH_W   = ch_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] load_valid;

  // NOTE: defaults come first so no path through the loop infers a latch.
  always_comb begin
    cfg_ready  = 1'b1;
    load_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready     = ~pend[i];
        load_valid[i] = cfg_valid;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load_valid (load_valid[g]),
      .load_div   (cfg_div),
      .pend       (pend[g]),
      .clk_out    (clk_out[g]),
      .tick       (tick[g])
    );
  end

endmodule
